dcache_victim_writer: RTL and testbench
=======================================

DCACHE_VICTIM_WRITER -- requirements
Module: dcache_victim_writer

Interface
REQ-001 SHALL have parameter OFFSET_WIDTH, default 4, line offset bits; line holds 2^(OFFSET_WIDTH-2) 32-bit words, W words.
REQ-002 SHALL have parameter TAG_WIDTH, default 20, tag bits of victim address.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port victim_valid  input  1  cache offers evicted line.
REQ-006 SHALL have port victim_dirty  input  1  offered line is dirty.
REQ-007 SHALL have port victim_addr  input  32  line base address; offset bits ignored.
REQ-008 SHALL have port victim_data  input  32*W  line data, word 0 in bits [31:0].
REQ-009 SHALL have port victim_ready  output  1  buffer empty, offer accepted this cycle.
REQ-010 SHALL have ports mem_req output 1, mem_wr output 1, mem_size output 2, mem_addr output 32, mem_wdata output 32: SRAM-like write request.
REQ-011 SHALL have ports mem_addr_ok input 1, mem_data_ok input 1: request accepted / write completed.
REQ-012 SHALL have ports lookup_addr input 32, lookup_hit output 1, lookup_data output 32: line-conflict probe from cache.
REQ-013 SHALL have port busy  output 1  drain in progress.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT; victim_ready = (state==IDLE); busy = !IDLE.
REQ-015 IDLE: on victim_valid && victim_dirty, capture addr (offset zeroed) and data, word index 0, go REQ next cycle.
REQ-016 IDLE: victim_valid && !victim_dirty SHALL be accepted and dropped; no memory traffic, stay IDLE.
REQ-017 REQ: mem_req=1, mem_wr=1, mem_size=2'b10, mem_addr=base+4*index, mem_wdata=word[index]; hold all stable until mem_addr_ok.
REQ-018 REQ with mem_addr_ok=1 SHALL go WAIT next cycle, mem_req deasserted in WAIT.
REQ-019 WAIT with mem_data_ok=1: if index==W-1 go IDLE, else index+1 and go REQ; only one write outstanding.
REQ-020 mem_data_ok in same cycle as mem_addr_ok in REQ SHALL be ignored; completion counted only in WAIT.
REQ-021 Index SHALL be OFFSET_WIDTH-2 bits, no wrap beyond W-1.
REQ-022 Drain of W words SHALL take minimum 2W cycles from leaving IDLE to returning IDLE with zero-latency memory.
REQ-023 A new victim SHALL be accepted in the first cycle back in IDLE (back-to-back).
REQ-024 mem_wr, mem_size, mem_addr, mem_wdata SHALL be 0 when mem_req=0.

Reset
REQ-025 resetn low SHALL immediately force IDLE, index 0, captured address/data 0, mem_req 0, busy 0, lookup_hit 0, lookup_data 0; victim_ready 1.
REQ-026 Reset mid-drain SHALL abandon remaining words; no request after resetn rises until a new victim.

Configuration
REQ-027 Macro DCACHE_WB_FORWARD_EN SHALL control lookup.
REQ-028 Defined: lookup_hit = busy && lookup_addr[31:OFFSET_WIDTH]==captured line address, combinational; lookup_data = captured word lookup_addr[OFFSET_WIDTH-1:2] when hit, else 0.
REQ-029 Not defined: lookup_hit = busy && line match (conflict stall only), lookup_data = 0.

Verification
REQ-030 W=4, dirty victim addr 0x1000_0014, data words 0xA0..0xA3, addr_ok/data_ok immediate -> writes 0x1000_0010..0x1000_001C with 0xA0..0xA3, busy 8 cycles.
REQ-031 Clean victim offered -> victim_ready 1, mem_req never asserted.
REQ-032 mem_addr_ok delayed 3 cycles on word 2 -> mem_addr 0x1000_0018 and wdata 0xA2 held stable for 4 cycles.
REQ-033 resetn low during WAIT of word 1 -> mem_req 0, busy 0 same cycle; no further writes after release.
REQ-034 With DCACHE_WB_FORWARD_EN, lookup_addr 0x1000_0018 during drain -> lookup_hit 1, lookup_data 0xA2; without -> hit 1, data 0.
REQ-035 Second dirty victim held valid during drain -> accepted in first IDLE cycle, drain starts next cycle.

Source files
------------

// File: rtl/dcache_victim_writer.sv
// Write-back buffer that drains one evicted dirty cache line to memory a word at a time.
// Define DCACHE_WB_FORWARD_EN to forward buffered words to conflicting lookups.
module dcache_victim_writer #(
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned TAG_WIDTH    = 20
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   victim_valid,
    input  logic                                   victim_dirty,
    input  logic [31:0]                            victim_addr,
    input  logic [32*(1<<(OFFSET_WIDTH-2))-1:0]    victim_data,
    output logic                                   victim_ready,
    output logic                                   mem_req,
    output logic                                   mem_wr,
    output logic [1:0]                             mem_size,
    output logic [31:0]                            mem_addr,
    output logic [31:0]                            mem_wdata,
    input  logic                                   mem_addr_ok,
    input  logic                                   mem_data_ok,
    input  logic [31:0]                            lookup_addr,
    output logic                                   lookup_hit,
    output logic [31:0]                            lookup_data,
    output logic                                   busy
);

    localparam int unsigned W  = 1 << (OFFSET_WIDTH - 2);
    localparam int unsigned IW = OFFSET_WIDTH - 2;
    localparam int unsigned SW = 32 - TAG_WIDTH - OFFSET_WIDTH;
    localparam logic [IW-1:0] LastIdx = IW'(W - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            state_q;
    logic [IW-1:0]     idx_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [SW-1:0]     set_q;
    logic [32*W-1:0]   data_q;
    logic              line_match;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tag_q   <= '0;
            set_q   <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Clean victims are acknowledged by victim_ready and simply dropped.
                    if (victim_valid && victim_dirty) begin
                        tag_q   <= victim_addr[31 -: TAG_WIDTH];
                        set_q   <= victim_addr[31-TAG_WIDTH -: SW];
                        data_q  <= victim_data;
                        idx_q   <= '0;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (mem_addr_ok) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Completion only counts here, so a data_ok alongside addr_ok is ignored.
                    if (mem_data_ok) begin
                        if (idx_q == LastIdx) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= StReq;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        victim_ready = (state_q == StIdle);
        busy         = !victim_ready;
        mem_req      = (state_q == StReq);
        mem_wr       = mem_req;
        mem_size     = mem_req ? 2'b10 : 2'b00;
        mem_addr     = mem_req ? {tag_q, set_q, idx_q, 2'b00} : 32'd0;
        mem_wdata    = mem_req ? data_q[{idx_q, 5'd0} +: 32] : 32'd0;
        line_match   = ({tag_q, set_q} == lookup_addr[31:OFFSET_WIDTH]);
        lookup_hit   = busy && line_match;
`ifdef DCACHE_WB_FORWARD_EN
        lookup_data  = lookup_hit ? data_q[{lookup_addr[OFFSET_WIDTH-1:2], 5'd0} +: 32] : 32'd0;
`else
        lookup_data  = 32'd0;
`endif
    end

    logic unused_addr_bits;
`ifdef DCACHE_WB_FORWARD_EN
    assign unused_addr_bits = ^{victim_addr[OFFSET_WIDTH-1:0], lookup_addr[1:0]};
`else
    assign unused_addr_bits = ^{victim_addr[OFFSET_WIDTH-1:0], lookup_addr[OFFSET_WIDTH-1:0]};
`endif

endmodule

// File: tb/tb_dcache_victim_writer.sv
// Bench for dcache_victim_writer: directed scenarios plus random traffic against a line-level model.
module tb_dcache_victim_writer;

    localparam int OW = 4;
    localparam int W  = 1 << (OW - 2);
    localparam int DW = 32 * W;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          victim_valid = 1'b0;
    logic          victim_dirty = 1'b0;
    logic [31:0]   victim_addr = '0;
    logic [DW-1:0] victim_data = '0;
    logic          victim_ready;
    logic          mem_req, mem_wr;
    logic [1:0]    mem_size;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_addr_ok = 1'b0;
    logic          mem_data_ok = 1'b0;
    logic [31:0]   lookup_addr = '0;
    logic          lookup_hit;
    logic [31:0]   lookup_data;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    int busy_seen = 0;
    int held_seen = 0;

    // Line-level model: which line is buffered, which word is next, whether a write is in flight.
    logic        m_busy = 1'b0;
    logic        m_out = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_line = '0;
    logic [31:0] m_words [W];

    always #5 clk = ~clk;

    dcache_victim_writer #(
        .OFFSET_WIDTH (OW),
        .TAG_WIDTH    (20)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .victim_data  (victim_data),
        .victim_ready (victim_ready),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_out  = 1'b0;
        m_idx  = 0;
    endtask

    task automatic check_outputs();
        logic        req, hit;
        logic [31:0] ea, ed, ld;
        req = m_busy && !m_out;
        ea  = req ? m_line + 32'(4 * m_idx) : 32'd0;
        ed  = req ? m_words[m_idx] : 32'd0;
        hit = m_busy && (lookup_addr[31:OW] == m_line[31:OW]);
`ifdef DCACHE_WB_FORWARD_EN
        ld  = hit ? m_words[int'(lookup_addr[OW-1:2])] : 32'd0;
`else
        ld  = 32'd0;
`endif
        chk("victim_ready", 32'(victim_ready), 32'(!m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("mem_req", 32'(mem_req), 32'(req));
        chk("mem_wr", 32'(mem_wr), 32'(req));
        chk("mem_size", 32'(mem_size), req ? 32'd2 : 32'd0);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("lookup_hit", 32'(lookup_hit), 32'(hit));
        chk("lookup_data", lookup_data, ld);
    endtask

    task automatic model_update(input logic v, input logic d, input logic [31:0] a,
                                input logic [DW-1:0] dat, input logic aok, input logic dok);
        if (!m_busy) begin
            if (v && d) begin
                m_busy = 1'b1;
                m_out  = 1'b0;
                m_idx  = 0;
                m_line = a & ~32'((1 << OW) - 1);
                for (int i = 0; i < W; i++) m_words[i] = dat[32*i +: 32];
            end
        end else if (!m_out) begin
            if (aok) m_out = 1'b1;
        end else if (dok) begin
            if (m_idx == W - 1) begin
                m_busy = 1'b0;
            end else begin
                m_idx++;
                m_out = 1'b0;
            end
        end
    endtask

    task automatic step(input logic v, input logic d, input logic [31:0] a, input logic [DW-1:0] dat,
                        input logic aok, input logic dok, input logic [31:0] la);
        @(negedge clk);
        victim_valid = v;
        victim_dirty = d;
        victim_addr  = a;
        victim_data  = dat;
        mem_addr_ok  = aok;
        mem_data_ok  = dok;
        lookup_addr  = la;
        #1;
        check_outputs();
        busy_seen += int'(busy);
        if (mem_req && mem_addr == 32'h1000_0018 && mem_wdata == 32'hA2) held_seen++;
        @(posedge clk);
        model_update(v, d, a, dat, aok, dok);
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < W; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [DW-1:0] va, vb;
        logic [31:0]   la;
        logic          aok;
        int            stall, cnt;

        for (int i = 0; i < W; i++) begin
            m_words[i] = '0;
            va[32*i +: 32] = 32'hA0 + 32'(i);
            vb[32*i +: 32] = 32'hB0 + 32'(i);
        end

        // Reset state, observed while resetn is still low.
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Dirty line with zero-latency memory: four writes, busy for 2W cycles, forwarding probe.
        busy_seen = 0;
        step(1'b1, 1'b1, 32'h1000_0014, va, 1'b1, 1'b1, 32'h1000_0018);
        for (int c = 0; c < 40 && m_busy; c++)
            step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h1000_0018);
        chk("busy_cycles", 32'(busy_seen), 32'(2 * W));

        // Clean victims are taken and dropped with no memory traffic.
        for (int c = 0; c < 4; c++)
            step(1'b1, 1'b0, $urandom, rand_line(), 1'b1, 1'b1, 32'h1000_0018);

        // Address phase of word 2 stalled three cycles: request held for four.
        held_seen = 0;
        stall = 0;
        step(1'b1, 1'b1, 32'h1000_0014, va, 1'b1, 1'b1, 32'h0);
        for (int c = 0; c < 60 && m_busy; c++) begin
            aok = 1'b1;
            if (!m_out && m_idx == 2 && stall < 3) begin
                aok = 1'b0;
                stall++;
            end
            step(1'b0, 1'b0, 32'h0, '0, aok, 1'b1, 32'h1000_0010);
        end
        chk("held_cycles", 32'(held_seen), 32'd4);

        // Second victim held valid through a drain is taken in the first idle cycle.
        step(1'b1, 1'b1, 32'h1000_0014, va, 1'b1, 1'b1, 32'h1000_001C);
        cnt = 0;
        for (int c = 0; c < 40 && m_line != 32'h2000_0040; c++) begin
            step(1'b1, 1'b1, 32'h2000_0040, vb, 1'b1, 1'b1, 32'h1000_001C);
            cnt++;
        end
        chk("b2b_accept_step", 32'(cnt), 32'(2 * W + 1));
        for (int c = 0; c < 40 && m_busy; c++)
            step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h2000_0044);

        // Reset during the wait phase of word 1 abandons the line.
        step(1'b1, 1'b1, 32'h1000_0014, va, 1'b1, 1'b1, 32'h0);
        for (int c = 0; c < 20 && !(m_out && m_idx == 1); c++)
            step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h0);
        chk("reached_wait_word1", 32'(m_out && m_idx == 1), 32'd1);
        #2;
        resetn = 1'b0;
        lookup_addr = 32'h1000_0018;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++)
            step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h1000_0018);

        // Random traffic, including spurious handshakes and offers while busy.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(1) == 0) la = {m_line[31:OW], 4'($urandom)};
            else la = $urandom;
            step(($urandom % 3) == 0, $urandom_range(1) == 1, $urandom, rand_line(),
                 ($urandom % 3) != 0, ($urandom % 3) != 0, la);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
